// File: rtl/smg_encode_module.sv
// smg_encode_module: binary h/m/s to six segment codes for the scanner.
// Iterative shift-add-3 BCD conversion, then a lookup, then atomic update.
//
// Ports:
//   CLK, RSTn     clock, async active-low reset
//   Start         request a conversion (sampled only when idle)
//   Hour_Data     binary hours   (valid 0..23)
//   Min_Data      binary minutes (valid 0..59)
//   Sec_Data      binary seconds (valid 0..59)
//   Blank_Mask    per-digit blank, bit0 = Ten_SMG_Data0 .. bit5 = One_SMG_Data2
//   Dp_En         decimal point on One_SMG_Data0 / One_SMG_Data1
//   Busy, Done    conversion in flight / one-cycle completion pulse
//   *_SMG_Data*   segment codes {dp,g,f,e,d,c,b,a}
module smg_encode_module #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit HOUR_LZ_BLANK  = 1'b0
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Start,
  input  logic [4:0] Hour_Data,
  input  logic [5:0] Min_Data,
  input  logic [5:0] Sec_Data,
  input  logic [5:0] Blank_Mask,
  input  logic       Dp_En,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Ten_SMG_Data0,
  output logic [7:0] One_SMG_Data0,
  output logic [7:0] Ten_SMG_Data1,
  output logic [7:0] One_SMG_Data1,
  output logic [7:0] Ten_SMG_Data2,
  output logic [7:0] One_SMG_Data2
);

  localparam logic [7:0] BLANK =
    SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_ENCODE,
    S_UPDATE
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  // {tens[2:0], ones[3:0], bin[5:0]}
  logic [12:0] sh_h, sh_m, sh_s;
  logic [5:0]  mask_q;
  logic        dp_q;
  logic        rng_h, rng_m, rng_s;
  logic [7:0]  stg [6];
  logic [7:0]  enc [6];

  function automatic logic [12:0] dd_step(
    input logic [12:0] v
  );
    logic [2:0] t;
    logic [3:0] o;
    t = v[12:10];
    o = v[9:6];
    if (o >= 4'd5) o = o + 4'd3;
    // Tens never reaches 5 before a shift for
    // 6-bit inputs; kept for a uniform step.
    if (t >= 3'd5) t = t + 3'd3;
    return {t, o, v[5:0]} << 1;
  endfunction

  function automatic logic [7:0] lut(
    input logic [3:0] d
  );
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  // Blanking wins over dash, dash over the
  // leading-zero blank; dp only on lit digits.
  function automatic logic [7:0] seg(
    input logic       bm,
    input logic       rng,
    input logic       lz,
    input logic       dp,
    input logic [3:0] d
  );
    logic       b;
    logic [7:0] c;
    b = bm | (~rng & lz);
    if (b)        c = 8'hFF;
    else if (rng) c = 8'hBF;
    else          c = lut(d);
    if (!b && dp) c[7] = 1'b0;
    return SEG_ACTIVE_LOW ? c : ~c;
  endfunction

  logic lz_h;
  assign lz_h = HOUR_LZ_BLANK &&
                (sh_h[12:10] == 3'd0);

  always_comb begin
    enc[0] = seg(mask_q[0], rng_h, lz_h, 1'b0,
                 {1'b0, sh_h[12:10]});
    enc[1] = seg(mask_q[1], rng_h, 1'b0, dp_q,
                 sh_h[9:6]);
    enc[2] = seg(mask_q[2], rng_m, 1'b0, 1'b0,
                 {1'b0, sh_m[12:10]});
    enc[3] = seg(mask_q[3], rng_m, 1'b0, dp_q,
                 sh_m[9:6]);
    enc[4] = seg(mask_q[4], rng_s, 1'b0, 1'b0,
                 {1'b0, sh_s[12:10]});
    enc[5] = seg(mask_q[5], rng_s, 1'b0, 1'b0,
                 sh_s[9:6]);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state         <= S_IDLE;
      cnt           <= 3'd0;
      sh_h          <= 13'd0;
      sh_m          <= 13'd0;
      sh_s          <= 13'd0;
      mask_q        <= 6'd0;
      dp_q          <= 1'b0;
      rng_h         <= 1'b0;
      rng_m         <= 1'b0;
      rng_s         <= 1'b0;
      for (int i = 0; i < 6; i++)
        stg[i] <= BLANK;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Ten_SMG_Data0 <= BLANK;
      One_SMG_Data0 <= BLANK;
      Ten_SMG_Data1 <= BLANK;
      One_SMG_Data1 <= BLANK;
      Ten_SMG_Data2 <= BLANK;
      One_SMG_Data2 <= BLANK;
    end else begin
      Done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (Start) state <= S_LOAD;
        end
        S_LOAD: begin
          sh_h   <= {7'd0, 1'b0, Hour_Data};
          sh_m   <= {7'd0, Min_Data};
          sh_s   <= {7'd0, Sec_Data};
          mask_q <= Blank_Mask;
          dp_q   <= Dp_En;
          rng_h  <= Hour_Data > 5'd23;
          rng_m  <= Min_Data > 6'd59;
          rng_s  <= Sec_Data > 6'd59;
          cnt    <= 3'd0;
          Busy   <= 1'b1;
          state  <= S_SHIFT;
        end
        S_SHIFT: begin
          sh_h <= dd_step(sh_h);
          sh_m <= dd_step(sh_m);
          sh_s <= dd_step(sh_s);
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd5) state <= S_ENCODE;
        end
        S_ENCODE: begin
          for (int i = 0; i < 6; i++)
            stg[i] <= enc[i];
          state <= S_UPDATE;
        end
        S_UPDATE: begin
          Ten_SMG_Data0 <= stg[0];
          One_SMG_Data0 <= stg[1];
          Ten_SMG_Data1 <= stg[2];
          One_SMG_Data1 <= stg[3];
          Ten_SMG_Data2 <= stg[4];
          One_SMG_Data2 <= stg[5];
          Done          <= 1'b1;
          Busy          <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smg_encode_module.sv
// tb_smg_encode_module: scoreboard bench for smg_encode_module.
// dut0 default params, dut1 leading-zero blank, dut2 active-high.
module tb_smg_encode_module;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       Start;
  logic [4:0] Hour_Data;
  logic [5:0] Min_Data;
  logic [5:0] Sec_Data;
  logic [5:0] Blank_Mask;
  logic       Dp_En;
  logic       busy [3];
  logic       done [3];
  logic [7:0] sg [3][6];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    smg_encode_module #(
      .SEG_ACTIVE_LOW(g == 2 ? 1'b0 : 1'b1),
      .HOUR_LZ_BLANK (g == 1 ? 1'b1 : 1'b0)
    ) u_dut (
      .CLK          (CLK),
      .RSTn         (RSTn),
      .Start        (Start),
      .Hour_Data    (Hour_Data),
      .Min_Data     (Min_Data),
      .Sec_Data     (Sec_Data),
      .Blank_Mask   (Blank_Mask),
      .Dp_En        (Dp_En),
      .Busy         (busy[g]),
      .Done         (done[g]),
      .Ten_SMG_Data0(sg[g][0]),
      .One_SMG_Data0(sg[g][1]),
      .Ten_SMG_Data1(sg[g][2]),
      .One_SMG_Data1(sg[g][3]),
      .Ten_SMG_Data2(sg[g][4]),
      .One_SMG_Data2(sg[g][5])
    );
  end

  typedef struct {
    int          s;
    logic [47:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [47:0] outs(input int s);
    return {sg[s][0], sg[s][1], sg[s][2],
            sg[s][3], sg[s][4], sg[s][5]};
  endfunction

  task automatic kick(
    input logic [4:0] h,
    input logic [5:0] m,
    input logic [5:0] s,
    input logic [5:0] mk,
    input logic       dp
  );
    Hour_Data  = h;
    Min_Data   = m;
    Sec_Data   = s;
    Blank_Mask = mk;
    Dp_En      = dp;
    Start      = 1'b1;
  endtask

  // Counts edges after the accepting edge until Done.
  task automatic wait_done(
    input  int s,
    output int lat,
    output int bn,
    output bit atomic
  );
    logic [47:0] prev;
    @(posedge CLK); #1;
    Start  = 1'b0;
    prev   = outs(s);
    lat    = 99;
    bn     = 0;
    atomic = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge CLK); #1;
      if (busy[s]) bn++;
      if (done[s]) begin
        lat = k;
        break;
      end
      if (outs(s) !== prev) atomic = 1'b0;
    end
  endtask

  task automatic test_reset;
    RSTn = 1'b0;
    kick(0, 0, 0, 0, 0);
    Start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_total++;
    if (outs(0) !== 48'hFFFFFFFFFFFF)
      $display("FAIL reset_out0 got %h want ffffffffffff",
               outs(0));
    else n_pass++;
    n_total++;
    if (outs(2) !== 48'h0)
      $display("FAIL reset_out2 got %h want 0", outs(2));
    else n_pass++;
    n_total++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0)
      $display("FAIL reset_flags got %b%b want 00",
               done[0], busy[0]);
    else n_pass++;
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic test_basic;
    exp_t e;
    int   lat, bn;
    bit   at;
    exp_q.push_back('{0, 48'hF9A4B0999282});
    kick(12, 34, 56, 6'd0, 1'b0);
    wait_done(0, lat, bn, at);
    n_total++;
    if (lat !== 9)
      $display("FAIL basic_latency got %0d want 9", lat);
    else n_pass++;
    n_total++;
    if (!at)
      $display("FAIL basic_atomic got 0 want 1");
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (outs(e.s) !== e.v)
      $display("FAIL basic_value got %h want %h",
               outs(e.s), e.v);
    else n_pass++;
  endtask

  task automatic test_dp_max;
    exp_t e;
    int   lat, bn;
    bit   at;
    exp_q.push_back('{0, 48'hA43092109290});
    kick(23, 59, 59, 6'd0, 1'b1);
    wait_done(0, lat, bn, at);
    n_total++;
    if (bn !== 8)
      $display("FAIL dp_busy_len got %0d want 8", bn);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (outs(e.s) !== e.v)
      $display("FAIL dp_value got %h want %h",
               outs(e.s), e.v);
    else n_pass++;
  endtask

  task automatic test_range;
    exp_t e;
    int   lat, bn;
    bit   at;
    exp_q.push_back('{0, 48'hBFBFBFBFC0C0});
    kick(24, 60, 0, 6'd0, 1'b0);
    wait_done(0, lat, bn, at);
    e = exp_q.pop_front();
    n_total++;
    if (lat !== 9 || outs(e.s) !== e.v)
      $display("FAIL range_value got %h lat %0d want %h",
               outs(e.s), lat, e.v);
    else n_pass++;
  endtask

  task automatic test_lz_mask;
    exp_t e;
    int   lat, bn;
    bit   at;
    exp_q.push_back('{1, 48'hFF92C0F8C0FF});
    exp_q.push_back('{0, 48'hC092C0F8C0FF});
    kick(5, 7, 9, 6'b100000, 1'b0);
    wait_done(1, lat, bn, at);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_total++;
      if (lat !== 9 || outs(e.s) !== e.v)
        $display("FAIL lz_mask_dut%0d got %h want %h",
                 e.s, outs(e.s), e.v);
      else n_pass++;
    end
  endtask

  task automatic test_inverted;
    exp_t e;
    int   lat, bn;
    bit   at;
    exp_q.push_back('{2, 48'h065B4F666D7D});
    kick(12, 34, 56, 6'd0, 1'b0);
    wait_done(2, lat, bn, at);
    e = exp_q.pop_front();
    n_total++;
    if (lat !== 9 || outs(e.s) !== e.v)
      $display("FAIL inverted_value got %h want %h",
               outs(e.s), e.v);
    else n_pass++;
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int   lat;
    exp_q.push_back('{0, 48'hF9A4B0999282});
    kick(12, 34, 56, 6'd0, 1'b0);
    @(posedge CLK); #1;
    Start = 1'b0;
    lat = 99;
    for (int k = 1; k <= 30; k++) begin
      @(posedge CLK); #1;
      if (k == 2) kick(23, 59, 59, 6'd0, 1'b1);
      if (k == 3) Start = 1'b0;
      if (done[0]) begin
        lat = k;
        break;
      end
    end
    n_total++;
    if (lat !== 9)
      $display("FAIL ignore_latency got %0d want 9", lat);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (outs(e.s) !== e.v)
      $display("FAIL ignore_value got %h want %h",
               outs(e.s), e.v);
    else n_pass++;
    @(posedge CLK); #1;
    n_total++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0)
      $display("FAIL ignore_no_rerun got %b%b want 00",
               done[0], busy[0]);
    else n_pass++;
  endtask

  task automatic test_hold;
    int nd = 0;
    repeat (20) begin
      @(posedge CLK); #1;
      if (done[0]) nd++;
    end
    n_total++;
    if (nd !== 0 || outs(0) !== 48'hF9A4B0999282)
      $display("FAIL hold got %h dones %0d want f9a4b0999282",
               outs(0), nd);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   nd = 0;
    int   at [2] = '{0, 0};
    exp_q.push_back('{0, 48'hC0F9C0A4C0B0});
    kick(1, 2, 3, 6'd0, 1'b0);
    @(posedge CLK); #1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      if (done[0]) begin
        at[nd] = k;
        nd++;
        e = exp_q.pop_front();
        n_total++;
        if (outs(e.s) !== e.v)
          $display("FAIL b2b_value%0d got %h want %h",
                   nd, outs(e.s), e.v);
        else n_pass++;
        if (nd == 2) begin
          Start = 1'b0;
          break;
        end
        exp_q.push_back('{0, 48'hC099C092C082});
        kick(4, 5, 6, 6'd0, 1'b0);
      end
    end
    n_total++;
    if (nd !== 2 || at[0] !== 9 || at[1] !== 19)
      $display("FAIL b2b_timing got %0d@%0d,%0d want 2@9,19",
               nd, at[0], at[1]);
    else n_pass++;
    Start = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_abort;
    int nd = 0;
    kick(23, 59, 59, 6'd0, 1'b0);
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    RSTn = 1'b0;
    #1;
    n_total++;
    if (outs(0) !== 48'hFFFFFFFFFFFF || outs(2) !== 48'h0)
      $display("FAIL abort_blank got %h/%h want ff../00..",
               outs(0), outs(2));
    else n_pass++;
    n_total++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0)
      $display("FAIL abort_flags got %b%b want 00",
               busy[0], done[0]);
    else n_pass++;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (12) begin
      @(posedge CLK); #1;
      if (done[0]) nd++;
    end
    n_total++;
    if (nd !== 0 || outs(0) !== 48'hFFFFFFFFFFFF)
      $display("FAIL abort_no_done got %h dones %0d",
               outs(0), nd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dp_max();
    test_range();
    test_lz_mask();
    test_inverted();
    test_ignore_start();
    test_hold();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
